// File: rtl/arb_fcfs_queued_if.sv
// Arbiter bus bundle for arb_fcfs_queued.
// Parameter: N requester count; IDXW/CNTW derived the same way as in the arbiter.
// master (requester side / bench): drives init, enable, request, lock, mask.
// slave  (arbiter): drives grant, grant_index, granted, parked, locked,
//                   queue_count, timeout.
interface arb_fcfs_queued_if #(
    parameter int unsigned N = 8
);
    localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CNTW = $clog2(N + 1);

    logic            init;
    logic            enable;
    logic [N-1:0]    request;
    logic [N-1:0]    lock;
    logic [N-1:0]    mask;

    logic            parked;
    logic            granted;
    logic            locked;
    logic            timeout;
    logic [N-1:0]    grant;
    logic [IDXW-1:0] grant_index;
    logic [CNTW-1:0] queue_count;

    modport master (
        output init, enable, request, lock, mask,
        input  parked, granted, locked, timeout, grant, grant_index, queue_count
    );

    modport slave (
        input  init, enable, request, lock, mask,
        output parked, granted, locked, timeout, grant, grant_index, queue_count
    );
endinterface

// File: rtl/arb_fcfs_queued.sv
// First-come-first-served arbiter for N requesters with an explicit compacting
// arrival-order queue, lock/mask/park support and queue occupancy output.
// Optional feature macro: ARB_FCFS_TIMEOUT_EN -- bounds a locked owner to
// MAX_HOLD consecutive grant cycles when others are waiting.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - synchronous active-high reset
//   bus  - arb_fcfs_queued_if.slave: init/enable/request/lock/mask in;
//          grant/grant_index/granted/parked/locked/queue_count/timeout out
//          (all outputs registered).
module arb_fcfs_queued #(
    parameter int unsigned N          = 8,
    parameter int unsigned PARK_MODE  = 1,
    parameter int unsigned PARK_INDEX = 0,
    parameter int unsigned MAX_HOLD   = 16
) (
    input  logic             clk,
    input  logic             rst,
    arb_fcfs_queued_if.slave bus
);
    localparam int unsigned     IDXW       = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned     CNTW       = $clog2(N + 1);
    localparam logic            PARK_ON    = (PARK_MODE != 0);
    localparam logic [N-1:0]    PARK_GRANT = PARK_ON ? (N'(1) << PARK_INDEX) : '0;
    localparam logic [IDXW-1:0] PARK_IDX   = PARK_ON ? IDXW'(PARK_INDEX) : '0;

    // Elaboration-time guard on parameter ranges.
    if (N < 2 || N > 32 || PARK_INDEX >= N || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_param
        $error("arb_fcfs_queued: parameter out of range");
    end

    // Arrival-order queue (entry 0 is the oldest waiter) and current owner.
    logic [IDXW-1:0] r_q [N];
    logic [CNTW-1:0] r_qcnt;
    logic            r_own_v;
    logic [IDXW-1:0] r_own;

    logic [N-1:0]    r_grant;
    logic [IDXW-1:0] r_grant_index;
    logic            r_granted;
    logic            r_parked;
    logic            r_locked;
    logic            r_timeout;

    logic [IDXW-1:0] w_q [N];
    logic [CNTW-1:0] w_qcnt;
    logic            w_own_v;
    logic [IDXW-1:0] w_own;
    logic            w_keep;
    logic [N-1:0]    w_grant;
    logic [IDXW-1:0] w_grant_index;
    logic            w_granted;
    logic            w_parked;
    logic            w_locked;
    logic            w_timeout;
    logic            w_hold_exp;

`ifdef ARB_FCFS_TIMEOUT_EN
    localparam int unsigned HOLDW = 8;
    logic [HOLDW-1:0] r_hold;
    logic [HOLDW-1:0] w_hold;

    // Lock is ignored once the current owner has held for MAX_HOLD cycles.
    assign w_hold_exp = r_own_v && (r_hold >= HOLDW'(MAX_HOLD));

    // Consecutive cycles with the same owner; restarts at 1 on a new owner.
    always_comb begin
        w_hold = '0;
        if (w_own_v) begin
            if (!w_keep) begin
                w_hold = HOLDW'(1);
            end else if (r_hold >= HOLDW'(MAX_HOLD)) begin
                w_hold = r_hold;
            end else begin
                w_hold = r_hold + HOLDW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.init) begin
            r_hold <= '0;
        end else begin
            r_hold <= w_hold;
        end
    end
`else
    assign w_hold_exp = 1'b0;
`endif

    // Next queue, owner and grant outputs.
    always_comb begin
        logic [IDXW-1:0] fq [N];
        logic [N-1:0]    inq;
        int unsigned     fcnt;
        int unsigned     ncnt;
        int unsigned     start;
        logic            own_ok;
        logic            hold_lock;
        logic            pop;

        fq            = '{default: '0};
        inq           = '0;
        fcnt          = 0;
        ncnt          = 0;
        start         = 0;
        w_q           = '{default: '0};
        w_qcnt        = '0;
        w_own_v       = 1'b0;
        w_own         = '0;
        w_grant       = '0;
        w_grant_index = '0;
        w_granted     = 1'b0;
        w_parked      = 1'b0;
        w_locked      = 1'b0;

        // Drop queued entries that stopped requesting or became masked.
        for (int unsigned i = 0; i < N; i++) begin
            if (i < 32'(r_qcnt)) begin
                inq[r_q[i]] = 1'b1;
                if (bus.request[r_q[i]] && !bus.mask[r_q[i]]) begin
                    fq[IDXW'(fcnt)] = r_q[i];
                    fcnt            = fcnt + 1;
                end
            end
        end

        own_ok    = r_own_v && bus.request[r_own] && !bus.mask[r_own];
        hold_lock = own_ok && bus.lock[r_own] && !w_hold_exp;
        // Same-edge arrivals are not yet eligible, so "queue empty" uses fq.
        w_keep    = bus.enable && own_ok && (hold_lock || fcnt == 0);
        pop       = bus.enable && !w_keep && (fcnt != 0);
        w_timeout = bus.enable && own_ok && bus.lock[r_own] && w_hold_exp && (fcnt != 0);

        start = pop ? 1 : 0;
        for (int unsigned i = 0; i < N; i++) begin
            if (i >= start && i < fcnt) begin
                w_q[IDXW'(ncnt)] = fq[i];
                ncnt             = ncnt + 1;
            end
        end

        // New arrivals in ascending index order.
        for (int unsigned i = 0; i < N; i++) begin
            if (bus.request[i] && !bus.mask[i] && !inq[i] &&
                !(r_own_v && r_own == IDXW'(i))) begin
                w_q[IDXW'(ncnt)] = IDXW'(i);
                ncnt             = ncnt + 1;
            end
        end

        // A released owner that still wants the bus goes behind this edge's arrivals.
        if (own_ok && !w_keep) begin
            w_q[IDXW'(ncnt)] = r_own;
            ncnt             = ncnt + 1;
        end
        w_qcnt = CNTW'(ncnt);

        if (w_keep) begin
            w_own_v = 1'b1;
            w_own   = r_own;
        end else if (pop) begin
            w_own_v = 1'b1;
            w_own   = fq[0];
        end

        if (w_own_v) begin
            w_grant       = N'(1) << w_own;
            w_grant_index = w_own;
            w_granted     = 1'b1;
            w_locked      = w_keep && hold_lock;
        end else if (bus.enable) begin
            w_grant       = PARK_GRANT;
            w_grant_index = PARK_IDX;
            w_parked      = PARK_ON;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.init) begin
            r_q           <= '{default: '0};
            r_qcnt        <= '0;
            r_own_v       <= 1'b0;
            r_own         <= '0;
            r_grant       <= PARK_GRANT;
            r_grant_index <= PARK_IDX;
            r_granted     <= 1'b0;
            r_parked      <= PARK_ON;
            r_locked      <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_q           <= w_q;
            r_qcnt        <= w_qcnt;
            r_own_v       <= w_own_v;
            r_own         <= w_own;
            r_grant       <= w_grant;
            r_grant_index <= w_grant_index;
            r_granted     <= w_granted;
            r_parked      <= w_parked;
            r_locked      <= w_locked;
            r_timeout     <= w_timeout;
        end
    end

    assign bus.grant       = r_grant;
    assign bus.grant_index = r_grant_index;
    assign bus.granted     = r_granted;
    assign bus.parked      = r_parked;
    assign bus.locked      = r_locked;
    assign bus.timeout     = r_timeout;
    assign bus.queue_count = r_qcnt;
endmodule

// File: tb/tb_arb_fcfs_queued.sv
// Directed bench for arb_fcfs_queued (N=8, park on 0, MAX_HOLD=4).
// Expected grant order is queued as stimulus is applied and popped when a new
// grant is due.
module tb_arb_fcfs_queued;
    localparam int unsigned N = 8;

    logic clk = 1'b0;
    logic rst;

    arb_fcfs_queued_if #(.N(N)) bus ();

    arb_fcfs_queued #(
        .N(N), .PARK_MODE(1), .PARK_INDEX(0), .MAX_HOLD(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int unsigned sb [$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [7:0] g, input int unsigned idx,
                             input logic gd, input logic pk, input logic lk,
                             input int unsigned qc, input logic to);
        chk({tag, ".grant"},   32'(bus.grant),       32'(g));
        chk({tag, ".index"},   32'(bus.grant_index), idx);
        chk({tag, ".granted"}, 32'(bus.granted),     32'(gd));
        chk({tag, ".parked"},  32'(bus.parked),      32'(pk));
        chk({tag, ".locked"},  32'(bus.locked),      32'(lk));
        chk({tag, ".qcount"},  32'(bus.queue_count), qc);
        chk({tag, ".timeout"}, 32'(bus.timeout),     32'(to));
    endtask

    task automatic expect_grant(input string tag, input logic lk, input int unsigned qc, input logic to);
        int unsigned e;
        e = 99;
        if (sb.size() != 0) e = sb.pop_front();
        chk_state(tag, 8'(1) << e, e, 1'b1, 1'b0, lk, qc, to);
    endtask

    task automatic idle_check(input string tag);
        chk_state(tag, 8'h01, 0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    endtask

    initial begin
        rst         = 1'b1;
        bus.init    = 1'b0;
        bus.enable  = 1'b1;
        bus.request = '0;
        bus.lock    = '0;
        bus.mask    = '0;
        step();
        step();
        rst = 1'b0;
        idle_check("reset");

        // Arrival order 2, 0, 5 then rotation.
        bus.request[2] = 1'b1; sb.push_back(2);
        step(); chk_state("order_enq", 8'h01, 0, 1'b0, 1'b1, 1'b0, 1, 1'b0);
        step(); expect_grant("order_g2", 1'b0, 0, 1'b0);
        bus.request[0] = 1'b1; sb.push_back(0);
        step(); chk_state("order_keep2", 8'h04, 2, 1'b1, 1'b0, 1'b0, 1, 1'b0);
        bus.request[5] = 1'b1; sb.push_back(5);
        sb.push_back(2); sb.push_back(0); sb.push_back(5);
        step(); expect_grant("order_g0",  1'b0, 2, 1'b0);
        step(); expect_grant("order_g5",  1'b0, 2, 1'b0);
        step(); expect_grant("order_g2b", 1'b0, 2, 1'b0);
        step(); expect_grant("order_g0b", 1'b0, 2, 1'b0);
        step(); expect_grant("order_g5b", 1'b0, 2, 1'b0);
        bus.request = '0;
        step(); idle_check("order_idle");

        // Same-edge arrivals: lower index first.
        bus.request[3] = 1'b1; bus.request[1] = 1'b1;
        sb.push_back(1); sb.push_back(3);
        step(); chk_state("tie_enq", 8'h01, 0, 1'b0, 1'b1, 1'b0, 2, 1'b0);
        step(); expect_grant("tie_g1", 1'b0, 1, 1'b0);
        step(); expect_grant("tie_g3", 1'b0, 1, 1'b0);
        bus.request = '0;
        step(); idle_check("tie_idle");

        // Lock holds the owner while another waits.
        bus.request[4] = 1'b1; bus.lock[4] = 1'b1; sb.push_back(4);
        step();
        step(); expect_grant("lock_g4", 1'b0, 0, 1'b0);
        bus.request[6] = 1'b1;
        step(); chk_state("lock_hold_a", 8'h10, 4, 1'b1, 1'b0, 1'b1, 1, 1'b0);
        step(); chk_state("lock_hold_b", 8'h10, 4, 1'b1, 1'b0, 1'b1, 1, 1'b0);
        bus.lock[4] = 1'b0; sb.push_back(6);
        step(); expect_grant("lock_g6", 1'b0, 1, 1'b0);
        bus.request = '0;
        step(); idle_check("lock_idle");

        // Long lock: bounded by MAX_HOLD only when the timeout feature is built.
        bus.request[2] = 1'b1; bus.lock[2] = 1'b1; sb.push_back(2);
        step();
        step(); expect_grant("to_g2", 1'b0, 0, 1'b0);
        bus.request[5] = 1'b1;
        step(); chk_state("to_hold2", 8'h04, 2, 1'b1, 1'b0, 1'b1, 1, 1'b0);
        step(); chk_state("to_hold3", 8'h04, 2, 1'b1, 1'b0, 1'b1, 1, 1'b0);
        step(); chk_state("to_hold4", 8'h04, 2, 1'b1, 1'b0, 1'b1, 1, 1'b0);
`ifdef ARB_FCFS_TIMEOUT_EN
        sb.push_back(5); sb.push_back(2);
        step(); expect_grant("to_fire",  1'b0, 1, 1'b1);
        step(); expect_grant("to_after", 1'b0, 1, 1'b0);
`else
        for (int k = 0; k < 8; k++) begin
            step(); chk_state("lock_long", 8'h04, 2, 1'b1, 1'b0, 1'b1, 1, 1'b0);
        end
        bus.lock[2] = 1'b0; sb.push_back(5);
        step(); expect_grant("lock_long_rel", 1'b0, 1, 1'b0);
`endif
        bus.request = '0; bus.lock = '0;
        step(); idle_check("to_idle");

        // Mask removes a queued entry and revokes a masked owner.
        bus.request[0] = 1'b1; bus.lock[0] = 1'b1; sb.push_back(0);
        step();
        step(); expect_grant("mask_g0", 1'b0, 0, 1'b0);
        bus.request[1] = 1'b1; bus.request[3] = 1'b1; bus.request[7] = 1'b1;
        step(); chk_state("mask_q3", 8'h01, 0, 1'b1, 1'b0, 1'b1, 3, 1'b0);
        bus.mask[3] = 1'b1;
        step(); chk_state("mask_q2", 8'h01, 0, 1'b1, 1'b0, 1'b1, 2, 1'b0);
        bus.request[0] = 1'b0; bus.lock[0] = 1'b0;
        sb.push_back(1); sb.push_back(7); sb.push_back(1);
        step(); expect_grant("mask_g1",  1'b0, 1, 1'b0);
        step(); expect_grant("mask_g7",  1'b0, 1, 1'b0);
        step(); expect_grant("mask_g1b", 1'b0, 1, 1'b0);
        bus.mask[1] = 1'b1; sb.push_back(7);
        step(); expect_grant("mask_own_revoke", 1'b0, 0, 1'b0);
        step(); chk_state("mask_own_stay", 8'h80, 7, 1'b1, 1'b0, 1'b0, 0, 1'b0);

        // Enable low drops the grant and re-queues the owner.
        bus.mask = '0; bus.request[3] = 1'b0;
        step(); chk_state("en_arrive1", 8'h80, 7, 1'b1, 1'b0, 1'b0, 1, 1'b0);
        bus.enable = 1'b0;
        step(); chk_state("en_off",   8'h00, 0, 1'b0, 1'b0, 1'b0, 2, 1'b0);
        step(); chk_state("en_off_b", 8'h00, 0, 1'b0, 1'b0, 1'b0, 2, 1'b0);
        bus.enable = 1'b1; sb.push_back(1);
        step(); expect_grant("en_on", 1'b0, 1, 1'b0);

        // Synchronous init clears everything like reset.
        bus.init = 1'b1;
        step(); idle_check("init");
        bus.init = 1'b0;
        step(); chk_state("init_reenq", 8'h01, 0, 1'b0, 1'b1, 1'b0, 2, 1'b0);
        sb.push_back(1);
        step(); expect_grant("init_g1", 1'b0, 1, 1'b0);
        bus.request = '0;
        step(); idle_check("final_idle");

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
